// File: rtl/debug_cmd_trigger_if.sv
// rtl/debug_cmd_trigger_if.sv - received-byte strobe bundle from uart_rx into the debug command decoder
interface debug_cmd_trigger_if;
  logic       rx_valid;
  logic [7:0] rx_byte;

  modport master (output rx_valid, output rx_byte);
  modport slave  (input  rx_valid, input  rx_byte);
endinterface

// File: rtl/debug_cmd_trigger.sv
// rtl/debug_cmd_trigger.sv - serial debug command decoder: halt/resume/step control plus one-shot triggers
// Optional argument-byte timeout enabled by defining DBG_ARG_TIMEOUT_EN.
module debug_cmd_trigger #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PULSE_W       = 8,
  parameter bit          HALT_ON_RESET = 1'b0,
  parameter int unsigned TIMEOUT_CYC   = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  debug_cmd_trigger_if.slave   rx_if,
  output logic                 halt_o,
  output logic                 step_active_o,
  output logic [NUM_CH-1:0]    trig_o,
  output logic                 cmd_err_o,
  output logic                 busy_o
);

  localparam logic [7:0] OP_HALT   = 8'h48;
  localparam logic [7:0] OP_RESUME = 8'h52;
  localparam logic [7:0] OP_STEP   = 8'h53;
  localparam logic [7:0] OP_PULSE  = 8'h50;
  localparam int unsigned PCNT_W   = $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_STEP} state_e;

  state_e     state_q;
  logic       op_step_q;
  logic       halt_q;
  logic       step_active_q;
  logic       busy_q;
  logic       cmd_err_q;
  logic       ign_q;
  logic [7:0] step_cnt_q;

  logic accept;
  logic arg_pulse;
  logic ch_ok;

  // A strobe right after an accepted one is treated as a glitch and dropped.
  assign accept    = rx_if.rx_valid && !ign_q;
  assign arg_pulse = (state_q == ST_ARG) && accept && !op_step_q;
  assign ch_ok     = 32'(rx_if.rx_byte) < NUM_CH;

`ifdef DBG_ARG_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_step_q     <= 1'b0;
      halt_q        <= HALT_ON_RESET;
      step_active_q <= 1'b0;
      busy_q        <= 1'b0;
      cmd_err_q     <= 1'b0;
      ign_q         <= 1'b0;
      step_cnt_q    <= 8'd0;
`ifdef DBG_ARG_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      ign_q     <= accept;
      cmd_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (rx_if.rx_byte)
              OP_HALT:   halt_q <= 1'b1;
              OP_RESUME: halt_q <= 1'b0;
              OP_STEP, OP_PULSE: begin
                state_q   <= ST_ARG;
                busy_q    <= 1'b1;
                op_step_q <= (rx_if.rx_byte == OP_STEP);
`ifdef DBG_ARG_TIMEOUT_EN
                to_cnt_q  <= '0;
`endif
              end
              default:   cmd_err_q <= 1'b1;
            endcase
          end
        end
        ST_ARG: begin
          if (accept) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (op_step_q) begin
              // Stepping only makes sense from a halted core; n==0 is a silent no-op.
              if (!halt_q) begin
                cmd_err_q <= 1'b1;
              end else if (rx_if.rx_byte != 8'd0) begin
                state_q       <= ST_STEP;
                halt_q        <= 1'b0;
                step_active_q <= 1'b1;
                step_cnt_q    <= rx_if.rx_byte;
              end
            end else if (!ch_ok) begin
              cmd_err_q <= 1'b1;
            end
          end
`ifdef DBG_ARG_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        ST_STEP: begin
          if (accept && rx_if.rx_byte == OP_HALT) begin
            halt_q        <= 1'b1;
            step_active_q <= 1'b0;
            step_cnt_q    <= 8'd0;
            state_q       <= ST_IDLE;
          end else if (accept && rx_if.rx_byte == OP_RESUME) begin
            halt_q        <= 1'b0;
            step_active_q <= 1'b0;
            step_cnt_q    <= 8'd0;
            state_q       <= ST_IDLE;
          end else begin
            if (accept) cmd_err_q <= 1'b1;
            if (step_cnt_q == 8'd1) begin
              halt_q        <= 1'b1;
              step_active_q <= 1'b0;
              step_cnt_q    <= 8'd0;
              state_q       <= ST_IDLE;
            end else begin
              step_cnt_q <= step_cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic              load;

    assign load = arg_pulse && (rx_if.rx_byte == 8'(gi));

    // Reload on retrigger so a live pulse is only ever extended.
    always_comb begin
      pcnt_d = pcnt_q;
      if (load)                pcnt_d = PCNT_W'(PULSE_W);
      else if (pcnt_q != '0)   pcnt_d = pcnt_q - PCNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pcnt_q <= '0;
      else     pcnt_q <= pcnt_d;
    end

    assign trig_o[gi] = (pcnt_q != '0);
  end

  assign halt_o        = halt_q;
  assign step_active_o = step_active_q;
  assign cmd_err_o     = cmd_err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_debug_cmd_trigger.sv
// tb/tb_debug_cmd_trigger.sv - directed self-checking bench for debug_cmd_trigger
module tb_debug_cmd_trigger;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt, step_active, cmd_err, busy;
  logic [3:0] trig;
  int         n_chk = 0;
  int         n_err = 0;

  debug_cmd_trigger_if rx_if ();

  debug_cmd_trigger #(
    .NUM_CH(4), .PULSE_W(8), .HALT_ON_RESET(1'b1), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .rst(rst), .rx_if(rx_if),
    .halt_o(halt), .step_active_o(step_active), .trig_o(trig),
    .cmd_err_o(cmd_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_byte  = b;
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_byte  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_byte  = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_halt", halt, 1);
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_step", step_active, 0);
    check("rst_err", cmd_err, 0);

    // T1 resume
    send(8'h52);
    check("t1_resume_halt", halt, 0);

    // T2 step of 5 cycles
    send(8'h48);
    check("t2_halt", halt, 1);
    send(8'h53);
    check("t2_busy", busy, 1);
    check("t2_halt_in_arg", halt, 1);
    send(8'h05);
    check("t2_busy_clr", busy, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_halt_c%0d", i), halt, (i < 5) ? 0 : 1);
      check($sformatf("t2_step_c%0d", i), step_active, (i < 5) ? 1 : 0);
      tick(1);
    end

    // T3 pulse width, then retrigger extension on ch2
    send(8'h50);
    send(8'h00);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t3_ch0_c%0d", i), trig, (i < 8) ? 4'b0001 : 4'b0000);
      tick(1);
    end
    send(8'h50);
    send(8'h02);
    check("t3_ch2_start", trig, 4'b0100);
    send(8'h50);
    send(8'h02);
    check("t3_ch2_retrig", trig, 4'b0100);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check($sformatf("t3_ch2_ext_c%0d", i), trig, (i < 8) ? 4'b0100 : 4'b0000);
    end

    // T4 error cases
    send(8'h50);
    send(8'h07);
    check("t4_badch_err", cmd_err, 1);
    check("t4_badch_trig", trig, 0);
    tick(1);
    check("t4_err_1cyc", cmd_err, 0);
    send(8'h41);
    check("t4_unknown_err", cmd_err, 1);
    check("t4_unknown_busy", busy, 0);
    send(8'h52);
    check("t4_resumed", halt, 0);
    send(8'h53);
    check("t4_s_busy", busy, 1);
    check("t4_s_noerr", cmd_err, 0);
    send(8'h00);
    check("t4_s_running_err", cmd_err, 1);
    check("t4_s_running_halt", halt, 0);
    check("t4_s_running_step", step_active, 0);

    // n == 0 while halted: no release, no error
    send(8'h48);
    send(8'h53);
    send(8'h00);
    check("n0_err", cmd_err, 0);
    check("n0_halt", halt, 1);
    check("n0_step", step_active, 0);

    // Back-to-back strobe: second one ignored
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_byte  = 8'h41;
    tick(1);
    check("b2b_first_err", cmd_err, 1);
    tick(1);
    rx_if.rx_valid = 1'b0;
    check("b2b_second_ignored", cmd_err, 0);

    // T5 long step interrupted by P (error) then H
    send(8'h53);
    send(8'hFF);
    check("t5_step_on", step_active, 1);
    check("t5_halt_low", halt, 0);
    send(8'h50);
    check("t5_p_err", cmd_err, 1);
    check("t5_p_step_kept", step_active, 1);
    check("t5_p_notrig", trig, 0);
    check("t5_p_notbusy", busy, 0);
    tick(6);
    check("t5_still_step", step_active, 1);
    send(8'h48);
    check("t5_h_halt", halt, 1);
    check("t5_h_step", step_active, 0);
    check("t5_h_noerr", cmd_err, 0);

    // R during step: core keeps running
    send(8'h53);
    send(8'h10);
    check("r_step_on", step_active, 1);
    send(8'h52);
    check("r_step_off", step_active, 0);
    tick(20);
    check("r_runs", halt, 0);

    // Reset during ARG
    send(8'h48);
    send(8'h50);
    check("rarg_busy", busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("rarg_busy_clr", busy, 0);
    check("rarg_halt", halt, 1);
    tick(1);
    rst = 1'b0;
    send(8'h02);
    check("rarg_idle_err", cmd_err, 1);
    check("rarg_idle_trig", trig, 0);

`ifdef DBG_ARG_TIMEOUT_EN
    send(8'h50);
    check("t6_busy", busy, 1);
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      check($sformatf("t6_busy_c%0d", i), busy, (i < 20) ? 1 : 0);
      check($sformatf("t6_err_c%0d", i), cmd_err, (i == 20) ? 1 : 0);
    end
    tick(1);
    check("t6_err_clr", cmd_err, 0);
`else
    send(8'h50);
    tick(30);
    check("t6_wait_busy", busy, 1);
    check("t6_wait_noerr", cmd_err, 0);
    send(8'h01);
    check("t6_late_arg_trig", trig, 4'b0010);
    check("t6_late_arg_busy", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
